// File: rtl/mac_operand_sequencer_if.sv
// ----------------------------------------------------------------------------
// mac_operand_sequencer_if
//
// Bundles the operand write port, batch control, MAC operand/accumulator
// lines and the result port of mac_operand_sequencer.
//
// Signals:
//   in_data   [7:0]  operand pair, [3:0]=a, [7:4]=b
//   in_valid         write request
//   in_ready         buffer accepts a write
//   start            launch the buffered batch
//   busy             batch in progress (RUN, DRAIN, DONE)
//   op_a, op_b [3:0] operands presented to the MAC
//   acc_in    [7:0]  MAC accumulator value C
//   res_data  [7:0]  batch result, mod 256
//   res_valid        result available
//   res_ready        result consumed
//   res_ovf          true batch sum exceeded 255
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (producer, MAC, result consumer)
// ----------------------------------------------------------------------------
interface mac_operand_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic       busy;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] acc_in;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       res_ovf;

  modport slave (
    input  in_data, in_valid, start, acc_in, res_ready,
    output in_ready, busy, op_a, op_b, res_data, res_valid, res_ovf
  );

  modport master (
    output in_data, in_valid, start, acc_in, res_ready,
    input  in_ready, busy, op_a, op_b, res_data, res_valid, res_ovf
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// ----------------------------------------------------------------------------
// mac_operand_sequencer
//
// Buffers up to DEPTH operand pairs, streams them into a 4x4 MAC one per
// cycle on start, then returns the batch sum of products as the difference
// between the accumulator after the batch and a baseline captured in the
// first streaming cycle (the MAC has no clear).
//
// Parameters:
//   DEPTH  operand-pair buffer depth, 2..8
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mac_operand_sequencer_if.slave (write port, start/busy,
//          op_a/op_b to the MAC, acc_in from the MAC, result port)
//
// Optional build macro:
//   MAC_SEQ_OVF_DETECT_EN  when defined, an 11-bit true sum of the issued
//                          products is kept and res_ovf flags sums > 255;
//                          otherwise res_ovf is tied low.
// ----------------------------------------------------------------------------
module mac_operand_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mac_operand_sequencer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] count_reg,    count_next;
  logic [CNT_W-1:0] rd_ptr_reg,   rd_ptr_next;
  logic             first_reg,    first_next;
  logic [7:0]       base_reg,     base_next;
  logic [7:0]       res_data_reg, res_data_next;
  logic [3:0]       op_a_reg,     op_a_next;
  logic [3:0]       op_b_reg,     op_b_next;

  // Operand buffer; no reset, it is only read below the write count.
  logic [7:0] mem [DEPTH];

  logic       in_ready;
  logic       wr_fire;
  logic       launch;
  logic       handshake;
  logic [7:0] head_pair;
  logic [7:0] rd_pair;

  assign in_ready  = (state_reg == ST_IDLE) && (count_reg < CNT_W'(DEPTH));
  assign wr_fire   = bus.in_valid && in_ready;
  // A write in the same cycle as start belongs to the batch.
  assign launch    = (state_reg == ST_IDLE) && bus.start &&
                     ((count_reg != '0) || wr_fire);
  assign handshake = (state_reg == ST_DONE) && bus.res_ready;

  // Pair 0 is forwarded straight from the write port when the buffer was
  // empty, since it is being written on the very edge that launches the run.
  assign head_pair = (count_reg == '0) ? bus.in_data : mem[0];
  assign rd_pair   = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[count_reg[PTR_W-1:0]] <= bus.in_data;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    first_next    = 1'b0;
    base_next     = base_reg;
    res_data_next = res_data_reg;
    // Operands are zero except while streaming so the MAC accumulates
    // nothing outside a batch and the baseline stays exact.
    op_a_next     = '0;
    op_b_next     = '0;

    case (state_reg)
      ST_IDLE: begin
        if (wr_fire) begin
          count_next = count_reg + CNT_W'(1);
        end
        if (launch) begin
          state_next  = ST_RUN;
          rd_ptr_next = CNT_W'(1);
          first_next  = 1'b1;
          op_a_next   = head_pair[3:0];
          op_b_next   = head_pair[7:4];
        end
      end

      ST_RUN: begin
        // First RUN cycle: the MAC has not yet absorbed pair 0.
        if (first_reg) begin
          base_next = bus.acc_in;
        end
        if (rd_ptr_reg == count_reg) begin
          state_next = ST_DRAIN;
        end else begin
          op_a_next   = rd_pair[3:0];
          op_b_next   = rd_pair[7:4];
          rd_ptr_next = rd_ptr_reg + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        // acc_in now includes every product of the batch.
        res_data_next = bus.acc_in - base_reg;
        state_next    = ST_DONE;
      end

      ST_DONE: begin
        if (handshake) begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      first_reg    <= 1'b0;
      base_reg     <= '0;
      res_data_reg <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      first_reg    <= first_next;
      base_reg     <= base_next;
      res_data_reg <= res_data_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
    end
  end

`ifdef MAC_SEQ_OVF_DETECT_EN
  // 8 x 225 = 1800 fits in 11 bits.
  logic [10:0] sum_reg,     sum_next;
  logic        res_ovf_reg, res_ovf_next;
  logic [7:0]  prod;

  assign prod = {4'd0, op_a_reg} * {4'd0, op_b_reg};

  always_comb begin
    sum_next     = sum_reg;
    res_ovf_next = res_ovf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          sum_next = '0;
        end
      end
      ST_RUN: begin
        sum_next = sum_reg + {3'd0, prod};
      end
      ST_DRAIN: begin
        res_ovf_next = (sum_reg > 11'd255);
      end
      ST_DONE: begin
        if (handshake) begin
          res_ovf_next = 1'b0;
        end
      end
      default: begin
        sum_next = sum_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg     <= '0;
      res_ovf_reg <= 1'b0;
    end else begin
      sum_reg     <= sum_next;
      res_ovf_reg <= res_ovf_next;
    end
  end

  assign bus.res_ovf = res_ovf_reg;
`else
  assign bus.res_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.res_valid = (state_reg == ST_DONE);
  assign bus.res_data  = res_data_reg;
  assign bus.op_a      = op_a_reg;
  assign bus.op_b      = op_b_reg;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_operand_sequencer
//
// Directed bench for mac_operand_sequencer with a simple accumulating MAC
// attached. A transaction-level model (operand queue plus a cycle count since
// launch) predicts every output each cycle; directed tests also check
// hand-computed results and latencies.
// ----------------------------------------------------------------------------
module tb_mac_operand_sequencer;

  localparam int DEPTH = 8;
`ifdef MAC_SEQ_OVF_DETECT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_operand_sequencer_if bus ();

  mac_operand_sequencer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // MAC: C <= C + a*b, sharing the sequencer's reset.
  logic [7:0] mac_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_c <= '0;
    else        mac_c <= mac_c + ({4'd0, bus.op_a} * {4'd0, bus.op_b});
  end
  assign bus.acc_in = mac_c;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];      // buffered pairs
  logic [7:0] m_batch[$];  // pairs of the running batch
  bit         m_busy = 1'b0;
  int         m_t    = 0;  // edges since the launch edge
  int         m_res  = 0;
  int         m_ovf  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_batch.delete();
        m_busy = 1'b0;
        m_t    = 0;
      end else if (!m_busy) begin
        if (bus.in_valid && m_q.size() < DEPTH) m_q.push_back(bus.in_data);
        if (bus.start && m_q.size() > 0) begin
          int s;
          logic [7:0] p;
          s = 0;
          m_batch = m_q;
          foreach (m_batch[i]) begin
            p = m_batch[i];
            s += int'(p[3:0]) * int'(p[7:4]);
          end
          m_res  = s % 256;
          m_ovf  = (OVF_EN != 0 && s > 255) ? 1 : 0;
          m_busy = 1'b1;
          m_t    = 0;
        end
      end else if (m_t >= m_batch.size() + 1) begin
        if (bus.res_ready) begin
          m_busy = 1'b0;
          m_q.delete();
        end
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int ea, eb, ev;
        logic [7:0] p;
        ea = 0; eb = 0;
        if (m_busy && m_t < m_batch.size()) begin
          p  = m_batch[m_t];
          ea = int'(p[3:0]);
          eb = int'(p[7:4]);
        end
        ev = (m_busy && m_t >= m_batch.size() + 1) ? 1 : 0;
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("in_ready", int'(bus.in_ready), (!m_busy && m_q.size() < DEPTH) ? 1 : 0);
        chk("op_a", int'(bus.op_a), ea);
        chk("op_b", int'(bus.op_b), eb);
        chk("res_valid", int'(bus.res_valid), ev);
        chk("res_ovf", int'(bus.res_ovf), ev ? m_ovf : 0);
        if (ev) chk("res_data", int'(bus.res_data), m_res);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic write(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Launch (optionally with a same-cycle write) and wait for res_valid;
  // lat counts cycles from the launch edge.
  task automatic launch_wait(input bit wr, input logic [7:0] d, output int lat);
    bus.start    = 1'b1;
    bus.in_valid = wr;
    bus.in_data  = d;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.res_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic take(output int d, output int o);
    d = int'(bus.res_data);
    o = int'(bus.res_ovf);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat, d, o;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-pair batch after reset: 3*5 + 2*7 = 29
    write(8'h53);
    write(8'h72);
    launch_wait(1'b0, 8'h00, lat);
    chk("t1_latency", lat, 3);
    take(d, o);
    chk("t1_res_data", d, 8'h1D);
    chk("t1_res_ovf", o, 0);
    $display("batch (3,5),(2,7): res=0x%02h ovf=%0d lat=%0d", d[7:0], o, lat);

    // Nonzero baseline: 15*15 = 225 on top of accumulator 0x1D
    chk("t2_acc_before", int'(mac_c), 8'h1D);
    write(8'hFF);
    launch_wait(1'b0, 8'h00, lat);
    chk("t2_latency", lat, 2);
    take(d, o);
    chk("t2_res_data", d, 8'hE1);
    $display("batch (15,15): res=0x%02h ovf=%0d lat=%0d", d[7:0], o, lat);

    // Full buffer: 8 accepted, 9th refused; 8*225 = 1800 -> 0x08
    for (int i = 0; i < 8; i++) write(8'hFF);
    chk("t3_in_ready_full", int'(bus.in_ready), 0);
    write(8'hFF);
    launch_wait(1'b0, 8'h00, lat);
    chk("t3_latency", lat, 9);
    take(d, o);
    chk("t3_res_data", d, 8'h08);
    chk("t3_res_ovf", o, OVF_EN);
    $display("batch 8x(15,15): res=0x%02h ovf=%0d lat=%0d", d[7:0], o, lat);

    // Result backpressure: 1*1 + 3*2 = 7, with start/write pulsed in DONE
    write(8'h11);
    write(8'h23);
    launch_wait(1'b0, 8'h00, lat);
    for (int i = 0; i < 5; i++) begin
      chk("t4_res_data_hold", int'(bus.res_data), 8'h07);
      chk("t4_in_ready", int'(bus.in_ready), 0);
      bus.start    = (i == 2);
      bus.in_valid = (i == 2);
      bus.in_data  = 8'h44;
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4_still_done", int'(bus.res_valid), 1);
    take(d, o);
    chk("t4_res_data", d, 8'h07);
    chk("t4_idle_after", int'(bus.busy), 0);
    $display("backpressured batch: res=0x%02h ovf=%0d", d[7:0], o);

    // Empty start ignored (also proves the DONE-time write was dropped)
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_empty_start", int'(bus.busy), 0);
    // Start together with the only write: 1*2 = 2
    launch_wait(1'b1, 8'h21, lat);
    chk("t5_latency", lat, 2);
    take(d, o);
    chk("t5_res_data", d, 8'h02);
    $display("same-cycle write+start (1,2): res=0x%02h lat=%0d", d[7:0], lat);

    // Reset during the 3rd pair of a 6-pair batch
    write(8'h12); write(8'h23); write(8'h34);
    write(8'h45); write(8'h56); write(8'h67);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_pair3_a", int'(bus.op_a), 4);
    chk("t6_pair3_b", int'(bus.op_b), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_op_a", int'(bus.op_a), 0);
    chk("t6_rst_op_b", int'(bus.op_b), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.res_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", int'(bus.in_ready), 1);
    // Count was cleared: a single new pair gives 3*5 = 15
    write(8'h53);
    launch_wait(1'b0, 8'h00, lat);
    chk("t6_latency", lat, 2);
    take(d, o);
    chk("t6_res_data", d, 8'h0F);
    $display("after mid-run reset (3,5): res=0x%02h lat=%0d", d[7:0], lat);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
